uart_slip_decoder: RTL and testbench
====================================

# uart_slip_decoder

Sits directly downstream of the UART receiver and consumes its byte stream. Decodes SLIP framing: END 0xC0 delimits frames, ESC 0xDB introduces escapes, 0xDB 0xDC yields 0xC0 and 0xDB 0xDD yields 0xDB. Emits a valid/ready byte stream with an end-of-frame `out_last` flag. Flags malformed or oversized frames.

## Interface
- `MAX_LEN`, 256: maximum decoded bytes per frame; must be at least 1.
- `clk` input 1: clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `in_data` input 8: received byte from the UART receiver.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: the byte is accepted on a cycle with `in_valid && in_ready`.
- `out_data` output 8: decoded byte.
- `out_valid` output 1: output byte valid.
- `out_last` output 1: the output byte is the final byte of its frame.
- `out_ready` input 1: downstream accepts a byte on a cycle with `out_valid && out_ready`.
- `frame_err` output 1: one-cycle pulse on a framing error.
- `err_cnt` output 16: only present with `UART_SLIP_ERRCNT_EN`.

## Operation
- **Pending register.** Holds `pend_data` and `pend_valid`, one decoded byte deep. A byte is held until the next event shows whether it is last.
- **Output register.** Holds `out_data`, `out_valid` and `out_last`, AXI-style. `out_valid` is held, with data stable, until `out_ready`.
- **Input backpressure.** `in_ready = !out_valid || out_ready`, combinational. Every accepted input byte produces at most one output write.
- **Emit.** Copies the pending byte into the output register with `out_last` set to 0 or 1. Emit happens only on an accepted input byte.
- **Length counter.** `len_cnt` is `$clog2(MAX_LEN+1)` bits and counts decoded bytes in the current frame. It clears on frame end and on error.
- **Decoded byte D arrives with `len_cnt == MAX_LEN`.** Emit the pending byte with last=1. Pulse `frame_err`. Go to DROP.
- **Decoded byte D arrives otherwise.** If `pend_valid`, emit the pending byte with last=0. Then set pend=D and increment `len_cnt`.

State machine, evaluated only on accepted input bytes:
- **IDLE** (no frame byte yet):
  - END: stay in IDLE. Empty frames are silently skipped.
  - ESC: go to ESC.
  - Any other byte: decoded byte; go to DATA.
- **DATA:**
  - END: emit pending with last=1, clear pend, go to IDLE.
  - ESC: go to ESC.
  - Any other byte: decoded byte; stay in DATA.
- **ESC:**
  - 0xDC or 0xDD: decoded byte 0xC0 or 0xDB respectively; go to DATA.
  - END: if `pend_valid`, emit with last=1. Pulse `frame_err`. Go to IDLE.
  - Any other byte: if `pend_valid`, emit with last=1. Pulse `frame_err`. Go to DROP.
- **DROP:** discard all bytes until END, then go to IDLE. No output is produced.
- **Error with no pending byte.** `frame_err` pulses; nothing is emitted.
- **Async reset mid-frame.** Discards the pending byte and the frame in progress; no `out_last` is produced.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_last`=0, `frame_err`=0, `err_cnt`=0. `in_ready`=1 immediately after reset.
- **Latency.** A decoded byte reaches the output register 1 cycle after the following decoded byte, or the terminating END, is accepted. The last byte of a frame appears with `out_last`=1 the cycle after END is accepted.
- **Throughput.** One input byte per cycle while `out_ready` is held high.
- **`frame_err`.** Registered; asserted the cycle after the offending byte is accepted.
- **Output while stalled.** `out_valid` is never deasserted without a handshake, and data stays stable while `!out_ready`.
- **Simultaneous events.** When `out_ready` and a new emit occur in the same cycle, the output register reloads and no bubble is inserted.

## Configuration
- **`UART_SLIP_ERRCNT_EN` defined.**
  - Adds the `err_cnt[15:0]` port.
  - `err_cnt` increments on each `frame_err` pulse.
  - It saturates at 0xFFFF and clears only on reset.
- **`UART_SLIP_ERRCNT_EN` undefined.** The port and counter are absent; `frame_err` is unchanged.

## Structure
- **Package `uart_pkg`:**
  - `SLIP_END` = 8'hC0, `SLIP_ESC` = 8'hDB, `SLIP_ESC_END` = 8'hDC, `SLIP_ESC_ESC` = 8'hDD.
  - Enum `slip_state_t` with values IDLE, DATA, ESC, DROP.
- **Sub-module `uart_stream_reg`.** Holds data, valid and last and implements the `in_ready` rule. It is natural because the UART TX path reuses it.

## Test plan
- Input 0xC0 0x11 0x22 0xC0 with `out_ready`=1 -> outputs 0x11 (last=0), then 0x22 (last=1); no `frame_err`.
- Input 0xC0 0xDB 0xDC 0xDB 0xDD 0xC0 -> outputs 0xC0 (last=0), then 0xDB (last=1).
- Input 0x55 0xDB 0x41 0x66 0xC0 -> output 0x55 (last=1); one `frame_err` pulse; 0x66 dropped; `err_cnt`=1 when enabled.
- With `MAX_LEN`=4, input 0x01 through 0x06 then 0xC0 -> outputs 0x01 to 0x04 with last on 0x04; one `frame_err`; 0x05 and 0x06 dropped.
- Hold `out_ready`=0 for 10 cycles mid-frame -> `in_ready` drops; `out_data` is stable; after release every byte is delivered in order with none lost.
- Input 0xC0 0xC0 0xC0 -> no output; no error.
- Assert `rstn`=0 after 0x11 0x22 -> all outputs return to their reset values immediately; the next frame 0x33 0xC0 outputs 0x33 (last=1).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared SLIP definitions for the UART byte-stream blocks.
//   SLIP_END / SLIP_ESC           : frame delimiter and escape introducer
//   SLIP_ESC_END / SLIP_ESC_ESC   : escaped forms of END and ESC
//   slip_state_t                  : decoder state encoding
package uart_pkg;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    ESC,
    DROP
  } slip_state_t;

endpackage

// File: rtl/uart_stream_reg.sv
// One-entry valid/ready output register carrying data plus a last flag.
// Ports:
//   clk, rstn         : clock, asynchronous active-low reset
//   load              : write load_data/load_last into the register this cycle
//   load_data/last    : value to write
//   out_data/valid/last, out_ready : downstream valid/ready interface
//   in_ready          : upstream may hand over a new write this cycle
// The producer must only assert load when in_ready is high.
module uart_stream_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             in_ready
);

  // Free when empty or draining this cycle; reload on the handshake cycle avoids a bubble.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
      out_last  <= load_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_slip_decoder.sv
// SLIP frame decoder sitting behind the UART receiver.
// Removes END delimiters and escape sequences, emits decoded bytes as a
// valid/ready stream with out_last marking the final byte of each frame,
// and pulses frame_err on bad escapes or frames longer than MAX_LEN bytes.
// Ports:
//   clk, rstn                      : clock, asynchronous active-low reset
//   in_data, in_valid, in_ready    : received byte stream
//   out_data, out_valid, out_last, out_ready : decoded byte stream
//   frame_err                      : one-cycle error pulse
//   err_cnt                        : saturating error count, only with UART_SLIP_ERRCNT_EN
// Optional feature macro: UART_SLIP_ERRCNT_EN
module uart_slip_decoder
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
`ifdef UART_SLIP_ERRCNT_EN
  output logic        frame_err,
  output logic [15:0] err_cnt
`else
  output logic        frame_err
`endif
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  slip_state_t      state_q, state_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic             pend_valid_q, pend_valid_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             frame_err_q, frame_err_d;

  logic       accept;
  logic       emit;
  logic       emit_last;
  logic       dec_valid;
  logic [7:0] dec_byte;

  assign accept    = in_valid && in_ready;
  assign frame_err = frame_err_q;

  always_comb begin
    state_d      = state_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    len_d        = len_q;
    frame_err_d  = 1'b0;
    emit         = 1'b0;
    emit_last    = 1'b0;
    dec_valid    = 1'b0;
    dec_byte     = in_data;

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          // A bare END outside a frame is an empty frame: ignore it.
          if (in_data == SLIP_ESC) begin
            state_d = ESC;
          end else if (in_data != SLIP_END) begin
            dec_valid = 1'b1;
            state_d   = DATA;
          end
        end
        DATA: begin
          if (in_data == SLIP_END) begin
            emit         = pend_valid_q;
            emit_last    = 1'b1;
            pend_valid_d = 1'b0;
            len_d        = '0;
            state_d      = IDLE;
          end else if (in_data == SLIP_ESC) begin
            state_d = ESC;
          end else begin
            dec_valid = 1'b1;
          end
        end
        ESC: begin
          if (in_data == SLIP_ESC_END) begin
            dec_valid = 1'b1;
            dec_byte  = SLIP_END;
            state_d   = DATA;
          end else if (in_data == SLIP_ESC_ESC) begin
            dec_valid = 1'b1;
            dec_byte  = SLIP_ESC;
            state_d   = DATA;
          end else begin
            // Bad escape closes whatever was collected so far.
            emit         = pend_valid_q;
            emit_last    = 1'b1;
            frame_err_d  = 1'b1;
            pend_valid_d = 1'b0;
            len_d        = '0;
            state_d      = (in_data == SLIP_END) ? IDLE : DROP;
          end
        end
        DROP: begin
          if (in_data == SLIP_END) begin
            state_d = IDLE;
          end
        end
      endcase

      if (dec_valid) begin
        if (len_q == LEN_MAX) begin
          // Overflow: the held byte becomes the truncated frame's last byte.
          emit         = pend_valid_q;
          emit_last    = 1'b1;
          frame_err_d  = 1'b1;
          pend_valid_d = 1'b0;
          len_d        = '0;
          state_d      = DROP;
        end else begin
          emit         = pend_valid_q;
          emit_last    = 1'b0;
          pend_data_d  = dec_byte;
          pend_valid_d = 1'b1;
          len_d        = len_q + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      len_q        <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      len_q        <= len_d;
      frame_err_q  <= frame_err_d;
    end
  end

  uart_stream_reg #(
    .WIDTH(8)
  ) u_out_reg (
    .clk      (clk),
    .rstn     (rstn),
    .load     (emit),
    .load_data(pend_data_q),
    .load_last(emit_last),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .in_ready (in_ready)
  );

`ifdef UART_SLIP_ERRCNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt <= '0;
    end else if (frame_err_q && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_slip_decoder.sv
module tb_uart_slip_decoder;

  logic        clk;
  logic        rstn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        frame_err;
`ifdef UART_SLIP_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  uart_slip_decoder #(
    .MAX_LEN(4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
`ifdef UART_SLIP_ERRCNT_EN
    .frame_err(frame_err),
    .err_cnt  (err_cnt)
`else
    .frame_err(frame_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every handshaken output byte, as {last, data}.
  logic [8:0] got_q[$];
  always @(posedge clk) begin
    if (rstn && out_valid && out_ready) got_q.push_back({out_last, out_data});
  end

  typedef struct {
    logic [7:0] din;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic       ee;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for byte %0h", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_queue(input string name, input logic [8:0] exp[$]);
    chk({name, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      chk($sformatf("%s_%0d", name, i), {23'd0, got_q[i]}, {23'd0, exp[i]});
  endtask

  initial begin
    logic [8:0] exp_q[$];
    logic [31:0] act, exp;

    rstn = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, out_last, frame_err, in_ready, out_data},
        {1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
    rstn = 1'b1;

    // {input, out_valid, out_data, out_last, frame_err} after the byte is accepted
    vecs = '{
      // basic frame
      '{8'hC0, 0, 8'h00, 0, 0}, '{8'h11, 0, 8'h00, 0, 0},
      '{8'h22, 1, 8'h11, 0, 0}, '{8'hC0, 1, 8'h22, 1, 0},
      // escapes
      '{8'hC0, 0, 8'h00, 0, 0}, '{8'hDB, 0, 8'h00, 0, 0},
      '{8'hDC, 0, 8'h00, 0, 0}, '{8'hDB, 0, 8'h00, 0, 0},
      '{8'hDD, 1, 8'hC0, 0, 0}, '{8'hC0, 1, 8'hDB, 1, 0},
      // bad escape with pending byte
      '{8'h55, 0, 8'h00, 0, 0}, '{8'hDB, 0, 8'h00, 0, 0},
      '{8'h41, 1, 8'h55, 1, 1}, '{8'h66, 0, 8'h00, 0, 0},
      '{8'hC0, 0, 8'h00, 0, 0},
      // overflow at MAX_LEN=4
      '{8'h01, 0, 8'h00, 0, 0}, '{8'h02, 1, 8'h01, 0, 0},
      '{8'h03, 1, 8'h02, 0, 0}, '{8'h04, 1, 8'h03, 0, 0},
      '{8'h05, 1, 8'h04, 1, 1}, '{8'h06, 0, 8'h00, 0, 0},
      '{8'hC0, 0, 8'h00, 0, 0},
      // empty frames
      '{8'hC0, 0, 8'h00, 0, 0}, '{8'hC0, 0, 8'h00, 0, 0},
      '{8'hC0, 0, 8'h00, 0, 0},
      // bad escape with nothing pending
      '{8'hDB, 0, 8'h00, 0, 0}, '{8'h41, 0, 8'h00, 0, 1},
      '{8'hC0, 0, 8'h00, 0, 0}
    };

    for (int i = 0; i < vecs.size(); i++) begin
      in_data  = vecs[i].din;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      act = {20'd0, out_valid, out_valid ? out_data : 8'h00, out_valid & out_last, frame_err,
             in_ready};
      exp = {20'd0, vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].ee, 1'b1};
      chk($sformatf("vec_%0d_in_%0h", i, vecs[i].din), act, exp);
    end
    in_valid = 1'b0;
`ifdef UART_SLIP_ERRCNT_EN
    chk("err_cnt_after_table", {16'd0, err_cnt}, 32'd3);
`endif

    // Stall: downstream not ready mid-frame.
    got_q.delete();
    out_ready = 1'b0;
    send(8'hA1);
    send(8'hA2);
    in_data  = 8'hA3;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall_%0d", c), {in_ready, out_valid, out_data}, {1'b0, 1'b1, 8'hA1});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send(8'hA4);
    send(8'hC0);
    repeat (3) @(posedge clk);
    #1;
    exp_q = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h1A4};
    chk_queue("stall_order", exp_q);

    // Async reset mid-frame.
    got_q.delete();
    send(8'h11);
    send(8'h22);
    rstn = 1'b0;
    #1;
    chk("async_reset", {out_valid, out_last, frame_err, in_ready, out_data},
        {1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
`ifdef UART_SLIP_ERRCNT_EN
    chk("err_cnt_reset", {16'd0, err_cnt}, 32'd0);
`endif
    #2;
    rstn = 1'b1;
    send(8'h33);
    send(8'hC0);
    chk("post_reset_frame", {out_valid, out_last, out_data}, {1'b1, 1'b1, 8'h33});
    repeat (3) @(posedge clk);
    #1;
    exp_q = '{9'h133};
    chk_queue("post_reset_queue", exp_q);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
